// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and stall sequencer for the 5-stage RV32I pipeline. It generates the
//   stall and flush controls for the F/D, D/E, E/M and M/W registers and the
//   execute-stage operand forwarding selects. A BOOT/RUN/MEM_WAIT FSM holds fetch
//   after reset and tracks data-memory wait states, including a sticky timeout.
//   Two saturating counters record stall and control-flush cycles.
// Ports
//   i_clk, i_rstn             : clock, asynchronous active-low reset
//   i_rs1/rs2_addrD           : source registers in decode
//   i_rs1/rs2_addrE, i_rd_addrE, i_result_srcE, i_pc_srcE : execute stage info
//   i_rd_addrM, i_reg_wr_enM  : memory stage writer
//   i_rd_addrW, i_reg_wr_enW  : writeback stage writer
//   i_dmem_reqM/readyM        : data memory handshake
//   o_fwd_a/b_selE            : 00 regfile, 10 from M, 01 from W
//   o_stallF/D/E/M, o_flushD/E/W : pipeline register controls
//   o_mem_timeout             : sticky dmem timeout flag
//   o_stall_cnt, o_flush_cnt  : saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int P_BOOT_CYCLES = 2,
  parameter int P_MEM_TIMEOUT = 16,
  parameter int P_CNT_W       = 32
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [4:0]         i_rs1_addrD,
  input  logic [4:0]         i_rs2_addrD,
  input  logic [4:0]         i_rs1_addrE,
  input  logic [4:0]         i_rs2_addrE,
  input  logic [4:0]         i_rd_addrE,
  input  logic [1:0]         i_result_srcE,
  input  logic               i_pc_srcE,
  input  logic [4:0]         i_rd_addrM,
  input  logic               i_reg_wr_enM,
  input  logic [4:0]         i_rd_addrW,
  input  logic               i_reg_wr_enW,
  input  logic               i_dmem_reqM,
  input  logic               i_dmem_readyM,
  output logic [1:0]         o_fwd_a_selE,
  output logic [1:0]         o_fwd_b_selE,
  output logic               o_stallF,
  output logic               o_stallD,
  output logic               o_stallE,
  output logic               o_stallM,
  output logic               o_flushD,
  output logic               o_flushE,
  output logic               o_flushW,
  output logic               o_mem_timeout,
  output logic [P_CNT_W-1:0] o_stall_cnt,
  output logic [P_CNT_W-1:0] o_flush_cnt
);

  localparam int BW = $clog2(P_BOOT_CYCLES + 1);
  localparam int WW = $clog2(P_MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] boot_cnt;
  logic [WW-1:0] wait_cnt;
  logic          ms, lu;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (i_reg_wr_enM && i_rd_addrM != 5'd0 && i_rd_addrM == rs)      fwd_sel = 2'b10;
    else if (i_reg_wr_enW && i_rd_addrW != 5'd0 && i_rd_addrW == rs) fwd_sel = 2'b01;
    else                                                             fwd_sel = 2'b00;
  endfunction

  assign ms = i_dmem_reqM && !i_dmem_readyM;
  assign lu = (i_result_srcE == 2'b01) && (i_rd_addrE != 5'd0) &&
              ((i_rd_addrE == i_rs1_addrD) || (i_rd_addrE == i_rs2_addrD));

  // state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= BOOT;
    else         state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:     if (boot_cnt == BW'(P_BOOT_CYCLES - 1)) state_nxt = RUN;
      RUN:      if (ms)  state_nxt = MEM_WAIT;
      MEM_WAIT: if (!ms) state_nxt = RUN;
      default:  state_nxt = BOOT;
    endcase
  end

  // outputs; memory stall outranks redirect, which outranks load-use
  always_comb begin
    o_fwd_a_selE = 2'b00;
    o_fwd_b_selE = 2'b00;
    o_stallF = 1'b0;
    o_stallD = 1'b0;
    o_stallE = 1'b0;
    o_stallM = 1'b0;
    o_flushD = 1'b0;
    o_flushE = 1'b0;
    o_flushW = 1'b0;
    if (state == BOOT) begin
      o_stallF = 1'b1;
      o_flushD = 1'b1;
      o_flushE = 1'b1;
    end else begin
      o_fwd_a_selE = fwd_sel(i_rs1_addrE);
      o_fwd_b_selE = fwd_sel(i_rs2_addrE);
      if (ms) begin
        // flushD/E stay low so a pending redirect or load-use is seen again
        o_stallF = 1'b1;
        o_stallD = 1'b1;
        o_stallE = 1'b1;
        o_stallM = 1'b1;
        o_flushW = 1'b1;
      end else if (i_pc_srcE) begin
        o_flushD = 1'b1;
        o_flushE = 1'b1;
      end else if (lu) begin
        o_stallF = 1'b1;
        o_stallD = 1'b1;
        o_flushE = 1'b1;
      end
    end
  end

  // boot / wait counters and sticky timeout
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      boot_cnt      <= '0;
      wait_cnt      <= '0;
      o_mem_timeout <= 1'b0;
    end else begin
      boot_cnt <= (state == BOOT) ? boot_cnt + 1'b1 : '0;
      if (state == RUN && ms) begin
        wait_cnt <= WW'(1);
      end else if (state == MEM_WAIT && ms) begin
        if (wait_cnt != WW'(P_MEM_TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt + 1'b1 == WW'(P_MEM_TIMEOUT)) o_mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // saturating performance counters; redirects during BOOT are not counted
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (o_stallF && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 1'b1;
      if (state != BOOT && i_pc_srcE && !ms && o_flush_cnt != '1)
        o_flush_cnt <= o_flush_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and stall sequencer for the 5-stage RV32I pipeline. It drives the stall/flush controls of the F/D, D/E, E/M and M/W pipeline registers and the operand-forwarding selects used in the execute stage. A small FSM handles post-reset bubble insertion and multi-cycle data-memory wait states with timeout detection. Saturating stall and flush counters provide performance monitoring.

Parameters:
P_BOOT_CYCLES, 2, cycles after reset release during which fetch is held and D/E are flushed (min 1)
P_MEM_TIMEOUT, 16, consecutive dmem wait cycles that set the sticky timeout flag (min 2)
P_CNT_W, 32, width of the performance counters

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, asynchronous, active-low
i_rs1_addrD  in  5  rs1 of instruction in decode
i_rs2_addrD  in  5  rs2 of instruction in decode
i_rs1_addrE  in  5  rs1 of instruction in execute
i_rs2_addrE  in  5  rs2 of instruction in execute
i_rd_addrE  in  5  destination register in execute
i_result_srcE  in  2  result source in execute; 2'b01 = load
i_pc_srcE  in  1  taken branch, jal or jalr resolved in execute
i_rd_addrM  in  5  destination register in memory stage
i_reg_wr_enM  in  1  register write enable, memory stage
i_rd_addrW  in  5  destination register in writeback
i_reg_wr_enW  in  1  register write enable, writeback
i_dmem_reqM  in  1  memory stage issues a load or store
i_dmem_readyM  in  1  data memory completes the access this cycle
o_fwd_a_selE  out  2  00 register file, 10 ALU result from M, 01 result from W
o_fwd_b_selE  out  2  same encoding, for rs2
o_stallF  out  1  hold PC
o_stallD  out  1  hold F/D register
o_stallE  out  1  hold D/E register
o_stallM  out  1  hold E/M register
o_flushD  out  1  clear F/D register
o_flushE  out  1  clear D/E register (i_clear of D/E)
o_flushW  out  1  insert bubble into M/W register
o_mem_timeout  out  1  sticky; dmem wait reached P_MEM_TIMEOUT
o_stall_cnt  out  P_CNT_W  cycles with o_stallF=1
o_flush_cnt  out  P_CNT_W  cycles with a control-hazard flush

Behaviour:
- FSM states: BOOT, RUN, MEM_WAIT. Reset enters BOOT with boot counter 0.
- Reset values: o_stallF=1, o_flushD=1, o_flushE=1. All other stall and flush outputs 0, both fwd selects 00, o_mem_timeout=0, counters 0.
- BOOT:
  - o_stallF=1, o_flushD=1, o_flushE=1, fwd selects forced to 00. All other hazard logic is ignored.
  - Go to RUN after P_BOOT_CYCLES clock edges.
- Forwarding (combinational, RUN and MEM_WAIT):
  - a=10 if i_reg_wr_enM, i_rd_addrM!=0 and i_rd_addrM==i_rs1_addrE.
  - Else a=01 if i_reg_wr_enW, i_rd_addrW!=0 and i_rd_addrW==i_rs1_addrE.
  - Else a=00. M has priority over W. Same rule for b with i_rs2_addrE.
- Load-use (combinational): lu = (i_result_srcE==2'b01) and i_rd_addrE!=0 and (i_rd_addrE==i_rs1_addrD or i_rd_addrE==i_rs2_addrD).
- Memory stall: ms = i_dmem_reqM and not i_dmem_readyM. Applies the same cycle, valid in RUN and MEM_WAIT.
- Priority 1, ms=1: o_stallF, o_stallD, o_stallE, o_stallM = 1 and o_flushW=1. o_flushD and o_flushE = 0, so a pending branch or load-use is re-evaluated after the stall.
- Priority 2, i_pc_srcE=1: o_flushD=1, o_flushE=1, no stalls. This overrides lu because the decode instruction is squashed.
- Priority 3, lu=1: o_stallF=1, o_stallD=1, o_flushE=1.
- Otherwise all stall and flush outputs are 0.
- RUN -> MEM_WAIT on ms=1; the wait counter loads 1.
- In MEM_WAIT: while ms=1 the wait counter increments, saturating at P_MEM_TIMEOUT. When it equals P_MEM_TIMEOUT, o_mem_timeout is set at that edge.
- MEM_WAIT -> RUN when ms=0; the wait counter clears.
- o_mem_timeout clears only on reset. The stall continues after timeout; there is no abort.
- o_stall_cnt increments at each edge where o_stallF=1, BOOT included. o_flush_cnt increments at each edge where i_pc_srcE=1 and ms=0. Both saturate at all-ones.
- Reset asserted mid-operation: immediate return to the reset values; the FSM returns to BOOT.

Test Plan:
- Reset release with P_BOOT_CYCLES=2, no requests -> stallF/flushD/flushE high for 2 cycles, then all 0 and o_stall_cnt=2.
- rd_addrM=5 with wen, rd_addrW=5 with wen, rs1_addrE=5 -> fwd_a=10. Set rd_addrM=0 -> fwd_a=01. Set rs2_addrE=0 with rd_addrW=0 -> fwd_b=00.
- Load in E with rd_addrE=7, rs2_addrD=7 -> stallF=1, stallD=1, flushE=1 for exactly one cycle. With rd_addrE=0 -> no stall.
- i_pc_srcE=1 while lu=1 -> flushD=1, flushE=1, stallF=0, and o_flush_cnt increments by 1.
- dmem_req=1 with ready low for 3 cycles, plus pc_srcE=1 -> all stalls and flushW high for 3 cycles with flushD=0. Ready high -> flushD=1 the next cycle, state back to RUN.
- ready held low 16 cycles (P_MEM_TIMEOUT=16) -> o_mem_timeout rises after the 16th wait edge and stays 1 after ready. It clears only on i_rstn=0.
